// File: rtl/pm_responder.sv
// -----------------------------------------------------------------------------
// pm_responder
//
// Program-memory responder for the fetch unit. Owns a 2^ADDR_W x 16-bit
// instruction-word array, answers reads after WAIT+1 cycles, accepts
// single-cycle writes, and (optionally) fills the array from a little-endian
// byte stream before releasing the core.
//
// Build option:
//   PM_LOADER_EN  defined   -> boot loader present; FSM leaves reset in
//                              LD_LEN_LO and o_boot_done rises after the last
//                              loaded byte.
//                 undefined -> loader compiled out; FSM leaves reset in IDLE,
//                              o_boot_done=1 from the first cycle after reset,
//                              o_ld_ready=0, array comes from preload/init.
//
// Parameters:
//   ADDR_W  word-address width (array depth 2^ADDR_W)
//   WAIT    extra read wait states, 0..3
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-low reset
//   i_PMADDR     word address (bits above ADDR_W ignored)
//   i_PMRE       read request
//   i_PMWE       write request (wins over a simultaneous read)
//   i_PMDATA     write data
//   o_PMDATA     registered read data, held until the next read completes
//   o_PMRDY      one-cycle completion pulse for a read or write
//   i_ld_valid   loader byte valid
//   i_ld_byte    loader byte
//   o_ld_ready   loader can accept a byte
//   o_boot_done  array loaded, requests are being served
// -----------------------------------------------------------------------------
module pm_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_PMADDR,
  input  logic        i_PMRE,
  input  logic        i_PMWE,
  input  logic [15:0] i_PMDATA,
  output logic [15:0] o_PMDATA,
  output logic        o_PMRDY,
  input  logic        i_ld_valid,
  input  logic [7:0]  i_ld_byte,
  output logic        o_ld_ready,
  output logic        o_boot_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] WAIT_INIT = 2'(WAIT);

`ifdef PM_LOADER_EN
  typedef enum logic [2:0] {
    LD_LEN_LO, LD_LEN_HI, LD_DAT_LO, LD_DAT_HI, IDLE, RD_WAIT
  } state_t;
  localparam state_t RESET_STATE = LD_LEN_LO;
`else
  typedef enum logic {IDLE, RD_WAIT} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state, state_d;
  logic [ADDR_W-1:0] rd_addr, rd_addr_d;
  logic [1:0]        wait_cnt, wait_cnt_d;
  // A write is acknowledged one cycle after it lands, so the pulse lines up
  // with a read issued on the following edge seeing the new data.
  logic              wr_ack, wr_ack_d;
  logic              rdy_d;
  logic [15:0]       rdata_d;
  logic              boot_done_d;
  logic              ld_ready_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem [DEPTH];

`ifdef PM_LOADER_EN
  logic [7:0]        byte_lo, byte_lo_d;
  logic [15:0]       remain, remain_d;
  logic [ADDR_W-1:0] ld_addr, ld_addr_d;
  logic              ld_take;

  assign ld_take = i_ld_valid & o_ld_ready;

  // Upper address bits are deliberately dropped (modulo wrap).
  logic unused_ok;
  assign unused_ok = ^i_PMADDR;
`else
  // Upper address bits are dropped; loader inputs have no function here.
  logic unused_ok;
  assign unused_ok = ^{i_PMADDR, i_ld_valid, i_ld_byte};
`endif

  // NOTE: every signal assigned below gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    rd_addr_d   = rd_addr;
    wait_cnt_d  = wait_cnt;
    wr_ack_d    = 1'b0;
    rdy_d       = wr_ack;
    rdata_d     = o_PMDATA;
    boot_done_d = o_boot_done;
    ld_ready_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = i_PMADDR[ADDR_W-1:0];
    mem_wdata   = i_PMDATA;
`ifdef PM_LOADER_EN
    byte_lo_d   = byte_lo;
    remain_d    = remain;
    ld_addr_d   = ld_addr;
`endif

    case (state)
`ifdef PM_LOADER_EN
      LD_LEN_LO: begin
        ld_ready_d = 1'b1;
        if (ld_take) begin
          byte_lo_d = i_ld_byte;
          state_d   = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        ld_ready_d = 1'b1;
        if (ld_take) begin
          remain_d = {i_ld_byte, byte_lo};
          if ({i_ld_byte, byte_lo} == 16'd0) begin
            state_d     = IDLE;
            ld_ready_d  = 1'b0;
            boot_done_d = 1'b1;
          end else begin
            state_d = LD_DAT_LO;
          end
        end
      end
      LD_DAT_LO: begin
        ld_ready_d = 1'b1;
        if (ld_take) begin
          byte_lo_d = i_ld_byte;
          state_d   = LD_DAT_HI;
        end
      end
      LD_DAT_HI: begin
        ld_ready_d = 1'b1;
        if (ld_take) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = {i_ld_byte, byte_lo};
          ld_addr_d = ld_addr + 1'b1;
          remain_d  = remain - 16'd1;
          if (remain == 16'd1) begin
            state_d     = IDLE;
            ld_ready_d  = 1'b0;
            boot_done_d = 1'b1;
          end else begin
            state_d = LD_DAT_LO;
          end
        end
      end
`endif
      IDLE: begin
        // Without the loader this is what raises o_boot_done after reset.
        boot_done_d = 1'b1;
        if (i_PMWE) begin
          mem_we   = 1'b1;
          wr_ack_d = 1'b1;
        end else if (i_PMRE) begin
          rd_addr_d  = i_PMADDR[ADDR_W-1:0];
          wait_cnt_d = WAIT_INIT;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_cnt != 2'd0) begin
          wait_cnt_d = wait_cnt - 2'd1;
        end else begin
          rdy_d   = 1'b1;
          rdata_d = mem[rd_addr];
          state_d = IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state       <= RESET_STATE;
      rd_addr     <= '0;
      wait_cnt    <= '0;
      wr_ack      <= 1'b0;
      o_PMRDY     <= 1'b0;
      o_PMDATA    <= '0;
      o_boot_done <= 1'b0;
      o_ld_ready  <= 1'b0;
`ifdef PM_LOADER_EN
      byte_lo     <= '0;
      remain      <= '0;
      ld_addr     <= '0;
`endif
    end else begin
      state       <= state_d;
      rd_addr     <= rd_addr_d;
      wait_cnt    <= wait_cnt_d;
      wr_ack      <= wr_ack_d;
      o_PMRDY     <= rdy_d;
      o_PMDATA    <= rdata_d;
      o_boot_done <= boot_done_d;
      o_ld_ready  <= ld_ready_d;
`ifdef PM_LOADER_EN
      byte_lo     <= byte_lo_d;
      remain      <= remain_d;
      ld_addr     <= ld_addr_d;
`endif
    end
  end

  // NOTE: the array has no reset; its contents survive reset and come from
  // the loader, writes, or preload/init.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_pm_responder.sv
// -----------------------------------------------------------------------------
// tb_pm_responder
//
// Four responders (WAIT = 0,1,2,3) share one stimulus bus so every scenario
// also exercises the full latency range. Instance 1 (WAIT=1) is the reference
// for the boot/read scenarios. Expected values are hand-computed constants.
// Works in both builds: with PM_LOADER_EN the array is filled via the loader
// stream, otherwise by bus writes.
// -----------------------------------------------------------------------------
module tb_pm_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pm_addr = '0;
  logic        pm_re = 1'b0;
  logic        pm_we = 1'b0;
  logic [15:0] pm_wdata = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;

  logic [15:0] rdata     [4];
  logic        rdy       [4];
  logic        ld_ready  [4];
  logic        boot_done [4];

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_read.
  int lat      [4];
  int npulse   [4];
  logic rdy_at_issue [4];

  always #5 clk = ~clk;

  for (genvar w = 0; w < 4; w++) begin : g_dut
    pm_responder #(.ADDR_W(10), .WAIT(w)) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_PMADDR    (pm_addr),
      .i_PMRE      (pm_re),
      .i_PMWE      (pm_we),
      .i_PMDATA    (pm_wdata),
      .o_PMDATA    (rdata[w]),
      .o_PMRDY     (rdy[w]),
      .i_ld_valid  (ld_valid),
      .i_ld_byte   (ld_byte),
      .o_ld_ready  (ld_ready[w]),
      .o_boot_done (boot_done[w])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at edge T, optionally keep re-requesting a2 for `extra`
  // more edges, then watch 7 edges and record first-pulse latency and count.
  task automatic run_read(input logic [15:0] a, input logic we, input logic [15:0] d,
                          input int extra, input logic [15:0] a2);
    for (int w = 0; w < 4; w++) begin
      lat[w] = 0;
      npulse[w] = 0;
    end
    pm_addr = a; pm_re = 1'b1; pm_we = we; pm_wdata = d;
    tick();
    pm_we = 1'b0;
    for (int w = 0; w < 4; w++) rdy_at_issue[w] = rdy[w];
    for (int k = 1; k <= 7; k++) begin
      pm_re = (k <= extra);
      if (k <= extra) pm_addr = a2;
      tick();
      for (int w = 0; w < 4; w++) begin
        if (rdy[w]) begin
          npulse[w]++;
          if (lat[w] == 0) lat[w] = k;
        end
      end
    end
    pm_re = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rdy[w] !== 1'b0 || rdata[w] !== 16'h0000 || ld_ready[w] !== 1'b0 || boot_done[w] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs w=%0d got rdy=%b data=%h ldr=%b done=%b expected 0/0000/0/0",
                 w, rdy[w], rdata[w], ld_ready[w], boot_done[w]);
      end
    end
    rst_n = 1'b1;
    tick();
`ifdef PM_LOADER_EN
    checks++;
    if (ld_ready[1] !== 1'b1 || boot_done[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ldr=%b done=%b expected 1/0", ld_ready[1], boot_done[1]);
    end
`else
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (boot_done[w] !== 1'b1 || ld_ready[w] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release w=%0d got done=%b ldr=%b expected 1/0", w, boot_done[w], ld_ready[w]);
      end
    end
`endif
  endtask

  task automatic test_boot();
`ifdef PM_LOADER_EN
    logic [7:0] stream [8] = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    for (int i = 0; i < 8; i++) begin
      send_byte(stream[i]);
      if (i == 6) begin
        checks++;
        if (boot_done[1] !== 1'b0) begin
          failures++;
          $display("FAIL boot_early got done=%b expected 0", boot_done[1]);
        end
      end
    end
    checks++;
    if (boot_done[1] !== 1'b1 || ld_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL boot_done got done=%b ldr=%b expected 1/0", boot_done[1], ld_ready[1]);
    end
`else
    logic [15:0] words [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    for (int i = 0; i < 3; i++) begin
      pm_addr = 16'(i); pm_wdata = words[i]; pm_we = 1'b1;
      tick();
      pm_we = 1'b0;
      tick();
    end
    checks++;
    if (ld_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL ld_ready_tied got %b expected 0", ld_ready[1]);
    end
`endif
  endtask

  task automatic test_read_basic();
    logic [15:0] exp [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    for (int i = 0; i < 3; i++) begin
      run_read(16'(i), 1'b0, 16'h0, 0, 16'h0);
      checks++;
      if (lat[1] !== 2 || npulse[1] !== 1 || rdata[1] !== exp[i]) begin
        failures++;
        $display("FAIL read_basic addr=%0d got lat=%0d pulses=%0d data=%h expected 2/1/%h",
                 i, lat[1], npulse[1], rdata[1], exp[i]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    run_read(16'd1, 1'b0, 16'h0, 0, 16'h0);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (lat[w] !== w + 1) begin
        failures++;
        $display("FAIL sweep_latency w=%0d got %0d expected %0d", w, lat[w], w + 1);
      end
      checks++;
      if (npulse[w] !== 1 || rdy_at_issue[w] !== 1'b0) begin
        failures++;
        $display("FAIL sweep_pulses w=%0d got %0d (issue rdy=%b) expected 1 (0)", w, npulse[w], rdy_at_issue[w]);
      end
      checks++;
      if (rdata[w] !== 16'h5678) begin
        failures++;
        $display("FAIL sweep_data w=%0d got %h expected 5678", w, rdata[w]);
      end
    end
  endtask

  task automatic test_boundary();
    run_read(16'h0401, 1'b0, 16'h0, 0, 16'h0);
    checks++;
    if (rdata[1] !== 16'h5678 || npulse[1] !== 1) begin
      failures++;
      $display("FAIL addr_wrap got data=%h pulses=%0d expected 5678/1", rdata[1], npulse[1]);
    end
  endtask

  task automatic test_write_read();
    pm_addr = 16'd5; pm_wdata = 16'h00FF; pm_we = 1'b1;
    tick();
    pm_we = 1'b0;
    checks++;
    if (rdy[1] !== 1'b0) begin
      failures++;
      $display("FAIL write_ack_early got %b expected 0", rdy[1]);
    end
    run_read(16'd5, 1'b0, 16'h0, 0, 16'h0);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rdy_at_issue[w] !== 1'b1 || lat[w] !== w + 1 || npulse[w] !== 1 || rdata[w] !== 16'h00FF) begin
        failures++;
        $display("FAIL write_then_read w=%0d got ack=%b lat=%0d pulses=%0d data=%h expected 1/%0d/1/00ff",
                 w, rdy_at_issue[w], lat[w], npulse[w], rdata[w], w + 1);
      end
    end
  endtask

  task automatic test_collisions();
    // Read and write together: only the write happens, one pulse, data held.
    run_read(16'd6, 1'b1, 16'hBEEF, 0, 16'h0);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (npulse[w] !== 1 || lat[w] !== 1 || rdata[w] !== 16'h00FF) begin
        failures++;
        $display("FAIL rw_collision w=%0d got pulses=%0d lat=%0d data=%h expected 1/1/00ff",
                 w, npulse[w], lat[w], rdata[w]);
      end
    end
    run_read(16'd6, 1'b0, 16'h0, 0, 16'h0);
    checks++;
    if (rdata[3] !== 16'hBEEF || lat[3] !== 4) begin
      failures++;
      $display("FAIL collision_write_data got data=%h lat=%0d expected beef/4", rdata[3], lat[3]);
    end
    // Second request while the first is pending is dropped.
    run_read(16'd0, 1'b0, 16'h0, 1, 16'd2);
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (npulse[w] !== 1 || lat[w] !== w + 1 || rdata[w] !== 16'h1234) begin
        failures++;
        $display("FAIL read_in_wait w=%0d got pulses=%0d lat=%0d data=%h expected 1/%0d/1234",
                 w, npulse[w], lat[w], rdata[w], w + 1);
      end
    end
  endtask

`ifdef PM_LOADER_EN
  task automatic test_len_zero();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h00);
    checks++;
    if (boot_done[1] !== 1'b0) begin
      failures++;
      $display("FAIL len0_first_byte got done=%b expected 0", boot_done[1]);
    end
    send_byte(8'h00);
    checks++;
    if (boot_done[1] !== 1'b1 || ld_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL len0_done got done=%b ldr=%b expected 1/0", boot_done[1], ld_ready[1]);
    end
    run_read(16'd1, 1'b0, 16'h0, 0, 16'h0);
    checks++;
    if (rdata[1] !== 16'h5678) begin
      failures++;
      $display("FAIL len0_retained got %h expected 5678", rdata[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick();
    checks++;
    if (ld_ready[1] !== 1'b0 || boot_done[1] !== 1'b0) begin
      failures++;
      $display("FAIL mid_load_reset got ldr=%b done=%b expected 0/0", ld_ready[1], boot_done[1]);
    end
    rst_n = 1'b1;
    tick();
    // A zero-length header only completes boot if the loader restarted at the length.
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (boot_done[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_restart got done=%b expected 1", boot_done[1]);
    end
    run_read(16'd0, 1'b0, 16'h0, 0, 16'h0);
    checks++;
    if (rdata[1] !== 16'h2211) begin
      failures++;
      $display("FAIL mid_load_word0 got %h expected 2211", rdata[1]);
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    int pulses;
    pm_addr = 16'd2; pm_re = 1'b1;
    tick();
    pm_re = 1'b0;
    rst_n = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rdy[w] !== 1'b0 || rdata[w] !== 16'h0000) begin
        failures++;
        $display("FAIL mid_read_reset w=%0d got rdy=%b data=%h expected 0/0000", w, rdy[w], rdata[w]);
      end
    end
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int w = 0; w < 4; w++) if (rdy[w] !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0 || rdata[3] !== 16'h0000) begin
      failures++;
      $display("FAIL mid_read_discard got pulses=%0d data=%h expected 0/0000", pulses, rdata[3]);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_read_basic();
    test_latency_sweep();
    test_boundary();
    test_write_read();
    test_collisions();
`ifdef PM_LOADER_EN
    test_len_zero();
    test_reset_mid_load();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pm_responder.md
# pm_responder

Program-memory responder for the fetch unit: serves the program-memory address, read-data and write-data bus that the fetch stage drives. It owns the instruction-word array, returns read data after a fixed, parameterised wait-state latency, and accepts program-memory writes. An optional byte-stream boot loader fills the array before the core is released.

## Interface

Parameters:
- ADDR_W, 10: word-address width; array depth is 2^ADDR_W 16-bit words.
- WAIT, 1: extra read wait states, range 0..3; read latency is WAIT+1 cycles.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_reset  in  1  reset, synchronous, active-low.
- i_PMADDR  in  16  word address from the fetch unit; bits above ADDR_W are ignored (modulo wrap).
- i_PMRE  in  1  read request, sampled on the clock edge.
- i_PMWE  in  1  write request, sampled on the clock edge.
- i_PMDATA  in  16  write data from the core.
- o_PMDATA  out  16  read data to the core, registered.
- o_PMRDY  out  1  one-cycle completion pulse for a read or write.
- i_ld_valid  in  1  loader byte valid.
- i_ld_byte  in  8  loader byte.
- o_ld_ready  out  1  loader can accept a byte.
- o_boot_done  out  1  array is loaded and requests are served; the core is held while this is 0.

## Operation

- One clock domain. All outputs are registered.
- Reset values: o_PMDATA=0, o_PMRDY=0, o_ld_ready=0, o_boot_done=0. The array is not cleared.
- FSM states: LD_LEN_LO, LD_LEN_HI, LD_DAT_LO, LD_DAT_HI, IDLE, RD_WAIT.
- Loader states (LD_*):
  - A byte is accepted on any edge where i_ld_valid=1 and o_ld_ready=1. o_ld_ready=1 in every LD_* state.
  - The stream is little-endian: a 16-bit word count N, then N words.
  - Words are written to addresses 0..N-1. The address counter is ADDR_W bits, so N > 2^ADDR_W wraps and overwrites.
  - N=0 goes from LD_LEN_HI directly to IDLE.
  - After the high byte of word N-1 is accepted: go to IDLE, set o_ld_ready=0, set o_boot_done=1.
  - i_PMRE and i_PMWE are ignored in LD_* states and o_PMRDY stays 0.
- IDLE:
  - i_PMWE=1: write i_PMDATA to the array at i_PMADDR on that edge; pulse o_PMRDY on the next cycle; stay in IDLE.
  - i_PMRE=1 (with i_PMWE=0): latch the address and go to RD_WAIT with wait counter = WAIT.
  - i_PMWE=1 and i_PMRE=1 together: the write wins and the read is dropped; the core must reissue it.
- RD_WAIT:
  - Counter nonzero: decrement.
  - Counter zero: load o_PMDATA from the latched address, pulse o_PMRDY, return to IDLE.
  - Requests arriving in RD_WAIT are ignored (no queue).
  - A write during the previous cycle's pending read is not possible; the single-outstanding rule prevents it.
- o_PMDATA holds its value until the next read completes. Writes do not change it.
- The loader ports are ignored outside LD_* states.

## Timing

- Read: request at edge T; o_PMRDY=1 and o_PMDATA valid during cycle T+1+WAIT. WAIT=0 gives the pulse in the cycle after the request.
- Write: the array is updated at edge T; o_PMRDY=1 during cycle T+1. A read of the same address issued at T+1 returns the new data.
- The next request may be issued in the same cycle as the o_PMRDY pulse.
- Reset mid-load: the FSM returns to LD_LEN_LO and the counters clear. Words already written remain.
- Reset mid-read: the read is discarded; o_PMRDY=0 and o_PMDATA=0.
- Boot: o_boot_done rises on the cycle after the last loader byte is accepted and stays 1 until reset.

## Configuration

- PM_LOADER_EN defined: the FSM leaves reset in LD_LEN_LO and the loader behaves as described in Operation.
- PM_LOADER_EN undefined:
  - The loader states and counters are compiled out.
  - The FSM leaves reset in IDLE, and o_boot_done=1 from the first cycle after reset releases.
  - o_ld_ready is tied to 0 and i_ld_* are ignored.
  - Array contents are supplied by simulation preload or synthesis init.

## Test plan

- Loader, PM_LOADER_EN, WAIT=1: stream 03 00 34 12 78 56 BC 9A -> o_boot_done=1 after the 8th byte; then read addresses 0, 1, 2 -> 1234, 5678, 9ABC, each with o_PMRDY two cycles after its request.
- Latency sweep WAIT=0..3: read address 1 -> o_PMRDY exactly WAIT+1 cycles after i_PMRE, as a single-cycle pulse, and o_PMDATA=5678 held afterwards.
- Write then read: write 0x00FF to address 5, then read address 5 on the next cycle -> o_PMRDY pulses for both and the read returns 0x00FF.
- Collisions: i_PMRE and i_PMWE together -> only the write takes effect and one o_PMRDY pulse occurs. A second i_PMRE during RD_WAIT -> ignored, giving one pulse only.
- Boundaries, ADDR_W=10: read address 0x0401 -> same data as address 1. Length 0 -> o_boot_done=1 two bytes after release.
- Reset mid-load: after two data bytes, pulse i_reset=0 for one cycle -> o_ld_ready=0 during reset, then the loader restarts at LD_LEN_LO and the word at address 0 is retained.
